// File: rtl/camera_power_down_seq.sv
// Power-down / re-wake sequencer for the OV5640 camera pair. Its outputs are override
// terms that the top level merges with the power-on delay block.
module camera_power_down_seq #(
    parameter int unsigned T_DRAIN = 25000,
    parameter int unsigned T_RST   = 250,
    parameter int unsigned T_PWDN  = 2500,
    parameter int unsigned T_RAIL  = 25000
) (
    input  logic clk_25m,
    input  logic reset,
    input  logic pd_req,
    input  logic pu_req,
    input  logic sccb_busy,
    output logic sccb_inhibit,
    output logic rstn_force_low,
    output logic pwdn_force_high,
    output logic rail_en,
    output logic off_done,
    output logic drain_timeout,
    output logic pon_restart
);

    typedef enum logic [2:0] {
        ST_ON    = 3'd0,
        ST_DRAIN = 3'd1,
        ST_RST   = 3'd2,
        ST_PWDN  = 3'd3,
        ST_OFF   = 3'd4,
        ST_WAKE  = 3'd5
    } state_t;

    localparam logic [19:0] LD_DRAIN = 20'(T_DRAIN - 1);
    localparam logic [19:0] LD_RST   = 20'(T_RST - 1);
    localparam logic [19:0] LD_PWDN  = 20'(T_PWDN - 1);
    localparam logic [19:0] LD_RAIL  = 20'(T_RAIL - 1);

    state_t      state;
    state_t      state_nxt;
    logic [19:0] cnt;
    logic [19:0] cnt_nxt;
    logic        cnt_zero;
    logic        timeout_exit;

    logic sccb_inhibit_nxt;
    logic rstn_force_low_nxt;
    logic pwdn_force_high_nxt;
    logic rail_en_nxt;
    logic off_done_nxt;
    logic drain_timeout_nxt;
    logic pon_restart_nxt;

    assign cnt_zero = (cnt == 20'd0);

    // State, shared counter and all outputs are registered together so they move on one edge
    always_ff @(posedge clk_25m) begin
        if (reset) begin
            state           <= ST_ON;
            cnt             <= 20'd0;
            sccb_inhibit    <= 1'b0;
            rstn_force_low  <= 1'b0;
            pwdn_force_high <= 1'b0;
            rail_en         <= 1'b1;
            off_done        <= 1'b0;
            drain_timeout   <= 1'b0;
            pon_restart     <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            sccb_inhibit    <= sccb_inhibit_nxt;
            rstn_force_low  <= rstn_force_low_nxt;
            pwdn_force_high <= pwdn_force_high_nxt;
            rail_en         <= rail_en_nxt;
            off_done        <= off_done_nxt;
            drain_timeout   <= drain_timeout_nxt;
            pon_restart     <= pon_restart_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        timeout_exit = 1'b0;
        case (state)
            ST_ON:    if (pd_req) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                // An idle bus wins over a simultaneous timeout
                if (!sccb_busy) begin
                    state_nxt = ST_RST;
                end else if (cnt_zero) begin
                    state_nxt    = ST_RST;
                    timeout_exit = 1'b1;
                end
            end
            ST_RST:   if (cnt_zero) state_nxt = ST_PWDN;
            ST_PWDN:  if (cnt_zero) state_nxt = ST_OFF;
            ST_OFF:   if (pu_req) state_nxt = ST_WAKE;
            ST_WAKE:  if (cnt_zero) state_nxt = ST_ON;
            default:  state_nxt = ST_ON;
        endcase

        cnt_nxt = cnt_zero ? 20'd0 : cnt - 20'd1;
        if (state_nxt != state) begin
            case (state_nxt)
                ST_DRAIN: cnt_nxt = LD_DRAIN;
                ST_RST:   cnt_nxt = LD_RST;
                ST_PWDN:  cnt_nxt = LD_PWDN;
                ST_WAKE:  cnt_nxt = LD_RAIL;
                default:  cnt_nxt = 20'd0;
            endcase
        end
    end

    always_comb begin
        sccb_inhibit_nxt    = 1'b1;
        rstn_force_low_nxt  = 1'b1;
        pwdn_force_high_nxt = 1'b1;
        rail_en_nxt         = 1'b1;
        off_done_nxt        = 1'b0;
        case (state_nxt)
            ST_ON: begin
                sccb_inhibit_nxt    = 1'b0;
                rstn_force_low_nxt  = 1'b0;
                pwdn_force_high_nxt = 1'b0;
            end
            ST_DRAIN: begin
                rstn_force_low_nxt  = 1'b0;
                pwdn_force_high_nxt = 1'b0;
            end
            ST_RST:   pwdn_force_high_nxt = 1'b0;
            ST_OFF: begin
                rail_en_nxt  = 1'b0;
                off_done_nxt = 1'b1;
            end
            default: ;
        endcase

        drain_timeout_nxt = drain_timeout;
        if (state == ST_ON && state_nxt == ST_DRAIN) begin
            drain_timeout_nxt = 1'b0;
        end else if (timeout_exit) begin
            drain_timeout_nxt = 1'b1;
        end

        pon_restart_nxt = (state == ST_WAKE) && (state_nxt == ST_ON);
    end

endmodule

// File: tb/tb_camera_power_down_seq.sv
// Bench for camera_power_down_seq: two instances (long and minimal timings) share one
// stimulus stream and are compared every cycle against a dwell-time reference model.
module tb_camera_power_down_seq;

    logic clk_25m = 1'b0;
    logic reset   = 1'b1;
    logic pd_req  = 1'b0;
    logic pu_req  = 1'b0;
    logic sccb_busy = 1'b0;

    logic sccb_inhibit_a, rstn_force_low_a, pwdn_force_high_a, rail_en_a;
    logic off_done_a, drain_timeout_a, pon_restart_a;
    logic sccb_inhibit_b, rstn_force_low_b, pwdn_force_high_b, rail_en_b;
    logic off_done_b, drain_timeout_b, pon_restart_b;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #20 clk_25m = ~clk_25m;

    camera_power_down_seq #(
        .T_DRAIN(25000), .T_RST(250), .T_PWDN(2500), .T_RAIL(8)
    ) dut_a (
        .clk_25m(clk_25m), .reset(reset), .pd_req(pd_req), .pu_req(pu_req),
        .sccb_busy(sccb_busy), .sccb_inhibit(sccb_inhibit_a),
        .rstn_force_low(rstn_force_low_a), .pwdn_force_high(pwdn_force_high_a),
        .rail_en(rail_en_a), .off_done(off_done_a), .drain_timeout(drain_timeout_a),
        .pon_restart(pon_restart_a)
    );

    camera_power_down_seq #(
        .T_DRAIN(16), .T_RST(1), .T_PWDN(1), .T_RAIL(1)
    ) dut_b (
        .clk_25m(clk_25m), .reset(reset), .pd_req(pd_req), .pu_req(pu_req),
        .sccb_busy(sccb_busy), .sccb_inhibit(sccb_inhibit_b),
        .rstn_force_low(rstn_force_low_b), .pwdn_force_high(pwdn_force_high_b),
        .rail_en(rail_en_b), .off_done(off_done_b), .drain_timeout(drain_timeout_b),
        .pon_restart(pon_restart_b)
    );

    logic [6:0] vec_a, vec_b;
    assign vec_a = {sccb_inhibit_a, rstn_force_low_a, pwdn_force_high_a, rail_en_a,
                    off_done_a, drain_timeout_a, pon_restart_a};
    assign vec_b = {sccb_inhibit_b, rstn_force_low_b, pwdn_force_high_b, rail_en_b,
                    off_done_b, drain_timeout_b, pon_restart_b};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: phase plus cycles already spent in it
    localparam int P_ON = 0, P_DRAIN = 1, P_RST = 2, P_PWDN = 3, P_OFF = 4, P_WAKE = 5;
    int t_drain [2] = '{25000, 16};
    int t_rst   [2] = '{250, 1};
    int t_pwdn  [2] = '{2500, 1};
    int t_rail  [2] = '{8, 1};
    int ph [2] = '{P_ON, P_ON};
    int dw [2] = '{0, 0};
    bit to [2] = '{1'b0, 1'b0};
    bit pr [2] = '{1'b0, 1'b0};

    task automatic enter(input int i, input int p);
        ph[i] = p;
        dw[i] = 1;
    endtask

    task automatic model_step(input int i);
        pr[i] = 1'b0;
        if (reset) begin
            ph[i] = P_ON; dw[i] = 0; to[i] = 1'b0;
        end else begin
            case (ph[i])
                P_ON:    if (pd_req) begin enter(i, P_DRAIN); to[i] = 1'b0; end
                P_DRAIN: if (!sccb_busy) enter(i, P_RST);
                         else if (dw[i] == t_drain[i]) begin enter(i, P_RST); to[i] = 1'b1; end
                         else dw[i]++;
                P_RST:   if (dw[i] == t_rst[i]) enter(i, P_PWDN); else dw[i]++;
                P_PWDN:  if (dw[i] == t_pwdn[i]) begin ph[i] = P_OFF; dw[i] = 0; end
                         else dw[i]++;
                P_OFF:   if (pu_req) enter(i, P_WAKE);
                P_WAKE:  if (dw[i] == t_rail[i]) begin ph[i] = P_ON; dw[i] = 0; pr[i] = 1'b1; end
                         else dw[i]++;
                default: ph[i] = P_ON;
            endcase
        end
    endtask

    function automatic logic [6:0] exp_vec(input int i);
        logic inh, rl, pw, rail, off;
        inh = (ph[i] != P_ON);
        rl  = (ph[i] == P_RST) || (ph[i] == P_PWDN) || (ph[i] == P_OFF) || (ph[i] == P_WAKE);
        pw  = (ph[i] == P_PWDN) || (ph[i] == P_OFF) || (ph[i] == P_WAKE);
        rail = (ph[i] != P_OFF);
        off  = (ph[i] == P_OFF);
        return {inh, rl, pw, rail, off, to[i], pr[i]};
    endfunction

    always @(posedge clk_25m) begin
        model_step(0);
        model_step(1);
    end

    always @(negedge clk_25m) begin
        if (chk_en) begin
            check("model_a", 32'(vec_a), 32'(exp_vec(0)));
            check("model_b", 32'(vec_b), 32'(exp_vec(1)));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_25m);
    endtask

    logic [5:0] b2b_trace [8];

    initial begin
        // {inhibit, rstn_force, pwdn_force, rail_en, off_done, pon_restart} after edges 0..7
        b2b_trace = '{6'b100100, 6'b110100, 6'b111100, 6'b111010,
                      6'b111100, 6'b000101, 6'b100100, 6'b110100};

        tick(1);
        chk_en = 1'b1;
        check("rst_vec_a", 32'(vec_a), 32'h08);
        check("rst_vec_b", 32'(vec_b), 32'h08);
        reset = 1'b0;
        tick(1);

        // Nominal shutdown, edge 0 is the pd_req sample
        pd_req = 1'b1; tick(1); pd_req = 1'b0;
        check("nom_inhibit_e0", 32'(sccb_inhibit_a), 32'd1);
        check("nom_rstn_e0", 32'(rstn_force_low_a), 32'd0);
        tick(1);
        check("nom_rstn_e1", 32'(rstn_force_low_a), 32'd1);
        tick(249);
        check("nom_pwdn_e250", 32'(pwdn_force_high_a), 32'd0);
        tick(1);
        check("nom_pwdn_e251", 32'(pwdn_force_high_a), 32'd1);
        tick(2499);
        check("nom_rail_e2750", 32'(rail_en_a), 32'd1);
        tick(1);
        check("nom_rail_e2751", 32'(rail_en_a), 32'd0);
        check("nom_off_e2751", 32'(off_done_a), 32'd1);
        check("nom_timeout", 32'(drain_timeout_a), 32'd0);

        // Wake at edge W, pd_req during WAKE
        pu_req = 1'b1; tick(1); pu_req = 1'b0;
        check("wake_rail_w", 32'(rail_en_a), 32'd1);
        check("wake_off_w", 32'(off_done_a), 32'd0);
        check("wake_rstn_w", 32'(rstn_force_low_a), 32'd1);
        tick(2);
        pd_req = 1'b1; tick(1); pd_req = 1'b0;
        tick(4);
        check("wake_pwdn_w7", 32'(pwdn_force_high_a), 32'd1);
        check("wake_pon_w7", 32'(pon_restart_a), 32'd0);
        tick(1);
        check("wake_forces_w8", 32'({sccb_inhibit_a, rstn_force_low_a, pwdn_force_high_a}), 32'd0);
        check("wake_pon_w8", 32'(pon_restart_a), 32'd1);
        tick(1);
        check("wake_pon_w9", 32'(pon_restart_a), 32'd0);
        check("wake_inhibit_w9", 32'(sccb_inhibit_a), 32'd0);

        reset = 1'b1; tick(1); reset = 1'b0;

        // Busy for 100 cycles: A waits, B (T_DRAIN=16) times out
        sccb_busy = 1'b1;
        pd_req = 1'b1; tick(1); pd_req = 1'b0;
        tick(15);
        check("to_rstn_e15", 32'(rstn_force_low_b), 32'd0);
        tick(1);
        check("to_rstn_e16", 32'(rstn_force_low_b), 32'd1);
        check("to_flag_e16", 32'(drain_timeout_b), 32'd1);
        tick(83);
        check("drain_rstn_e99", 32'(rstn_force_low_a), 32'd0);
        check("drain_inhibit_e99", 32'(sccb_inhibit_a), 32'd1);
        sccb_busy = 1'b0;
        tick(1);
        check("drain_rstn_e100", 32'(rstn_force_low_a), 32'd1);
        check("drain_timeout_a", 32'(drain_timeout_a), 32'd0);

        // B wakes and shuts down cleanly; A is in RST and ignores both requests
        pu_req = 1'b1; tick(1); pu_req = 1'b0;
        tick(1);
        check("to_pon_b", 32'(pon_restart_b), 32'd1);
        check("to_flag_held", 32'(drain_timeout_b), 32'd1);
        pd_req = 1'b1; tick(1); pd_req = 1'b0;
        check("to_flag_cleared", 32'(drain_timeout_b), 32'd0);
        check("ign_rstn_a", 32'(rstn_force_low_a), 32'd1);

        // Reset in the middle of PWDN
        tick(297);
        check("mid_pwdn_a", 32'(pwdn_force_high_a), 32'd1);
        reset = 1'b1; tick(1); reset = 1'b0;
        check("mid_rst_vec_a", 32'(vec_a), 32'h08);
        pu_req = 1'b1; tick(1); pu_req = 1'b0;
        tick(2);
        check("ign_pu_in_on", 32'(vec_a), 32'h08);

        // pd_req in OFF is ignored
        pd_req = 1'b1; tick(1); pd_req = 1'b0;
        tick(3);
        check("b_off", 32'(off_done_b), 32'd1);
        pd_req = 1'b1; tick(1); pd_req = 1'b0;
        tick(1);
        check("ign_pd_in_off", 32'({rail_en_b, off_done_b}), 32'b01);
        reset = 1'b1; tick(1); reset = 1'b0;

        // Back-to-back with both requests held high on the minimal-timing instance
        pd_req = 1'b1; pu_req = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick(1);
            check($sformatf("b2b_e%0d", e),
                  32'({sccb_inhibit_b, rstn_force_low_b, pwdn_force_high_b, rail_en_b,
                       off_done_b, pon_restart_b}), 32'(b2b_trace[e]));
        end
        pd_req = 1'b0; pu_req = 1'b0;
        reset = 1'b1; tick(1); reset = 1'b0;

        // Random traffic, checked every cycle by the model
        for (int n = 0; n < 20000; n++) begin
            pd_req    = ($urandom % 8) == 0;
            pu_req    = ($urandom % 8) == 0;
            sccb_busy = ($urandom % 4) != 0;
            reset     = ($urandom % 3000) == 0;
            tick(1);
        end
        pd_req = 1'b0; pu_req = 1'b0; reset = 1'b0;
        tick(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/camera_power_down_seq.md
# camera_power_down_seq

Orderly power-down and re-wake sequencer for the OV5640 camera pair, the shutdown-side counterpart of the power-on delay block. On request it quiesces SCCB, drives RESETB low, raises PWDN, then drops the sensor rails in datasheet order with fixed inter-step delays. On a wake request it restores rails and pulses a restart so the power-on sequencer replays its full timing. Outputs are override terms that the top level merges with the power-on block: rstn is ANDed with ~rstn_force_low, pwdn is ORed with pwdn_force_high, and SCCB start is gated by ~sccb_inhibit.

## Interface
- T_DRAIN, default 25000: maximum cycles to wait for SCCB idle (1 ms at 25 MHz).
- T_RST, default 250: cycles RESETB is held low before PWDN rises (10 us).
- T_PWDN, default 2500: cycles PWDN is held high before rails drop (100 us).
- T_RAIL, default 25000: rail-stabilise cycles on wake before the restart pulse (1 ms).
- clk_25m  in  1  25 MHz system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- pd_req  in  1  power-down request; sampled only in ON.
- pu_req  in  1  wake request; sampled only in OFF.
- sccb_busy  in  1  SCCB master transaction in progress.
- sccb_inhibit  out  1  blocks new SCCB transactions.
- rstn_force_low  out  1  forces camera1_rstn and camera2_rstn low.
- pwdn_force_high  out  1  forces camera_pwnd high.
- rail_en  out  1  sensor LDO enable.
- off_done  out  1  high while fully powered down (state OFF).
- drain_timeout  out  1  sticky flag: the last drain ended by timeout.
- pon_restart  out  1  one-cycle pulse; restarts the power-on sequencer.

## Operation
- States: ON, DRAIN, RST, PWDN, OFF, WAKE. All outputs are registered and change on the same edge the state changes.
- ON: all force outputs are 0, rail_en=1, sccb_inhibit=0. pd_req=1 moves to DRAIN.
- DRAIN: sccb_inhibit=1.
  - sccb_busy=0 moves to RST on the next edge.
  - If busy persists for T_DRAIN cycles, move to RST and set drain_timeout.
- RST: adds rstn_force_low=1. Held T_RST cycles, then PWDN.
- PWDN: adds pwdn_force_high=1. Held T_PWDN cycles, then OFF.
- OFF: rail_en=0, off_done=1, all forces held. pu_req=1 moves to WAKE.
- WAKE: rail_en=1, forces still held, off_done=0. Held T_RAIL cycles, then ON with pon_restart=1 for exactly that first ON cycle. All forces clear in the same cycle.
- drain_timeout is cleared on entry to DRAIN. It is set only on the timeout exit and holds until the next DRAIN entry or reset.
- Request handling:
  - pd_req outside ON and pu_req outside OFF are ignored, not queued.
  - pd_req and pu_req high together are resolved by state: only the one valid in the current state acts.
- Counter: one 20-bit down-counter shared by all timed states. It loads P-1 on state entry, and the state exits on the edge where it reads 0. Each parameter must be between 1 and 2^20-1. T_DRAIN counts cycles spent in DRAIN, including the entry cycle.
- Reset (at any time, including mid-sequence) forces ON:
  - forces=0, rail_en=1, sccb_inhibit=0, off_done=0, drain_timeout=0, pon_restart=0, counter=0.
  - A reset issued in OFF re-enables the rails without the WAKE delay. The top level must also reset the power-on block, which is documented system behaviour.

## Timing
- Edge-0 convention: pd_req is sampled high at edge 0 in ON.
  - sccb_inhibit rises after edge 0 (DRAIN).
  - With sccb_busy=0 at edge 1, rstn_force_low rises after edge 1.
  - pwdn_force_high rises after edge 1+T_RST.
  - rail_en falls and off_done rises after edge 1+T_RST+T_PWDN.
- pu_req is sampled high at edge W in OFF.
  - rail_en rises after edge W.
  - After edge W+T_RAIL: forces and sccb_inhibit clear and pon_restart pulses high for one cycle.
- Busy never clears: DRAIN lasts exactly T_DRAIN cycles, then RST is entered with drain_timeout=1.
- Minimum OFF dwell is one cycle. pu_req held high continuously from OFF entry wakes at the first OFF edge.

## Test plan
- Nominal shutdown with defaults and sccb_busy=0; pd_req pulse at edge 0 -> check the following transition edges:
  - rstn_force_low at 1.
  - pwdn_force_high at 251.
  - rail_en=0 and off_done=1 at 2751.
  - drain_timeout=0.
- Drain wait: sccb_busy high for 100 cycles after pd_req, then low -> RST entered one edge after busy is sampled low; drain_timeout=0.
- Drain timeout with T_DRAIN=16 and sccb_busy stuck high -> RST entered after exactly 16 DRAIN cycles; drain_timeout=1. A later clean shutdown clears it.
- Wake with T_RAIL=8; pu_req in OFF at edge W -> rail_en=1 at W; forces clear at W+8; pon_restart high for exactly one cycle; pd_req during WAKE has no effect.
- Reset asserted mid-PWDN -> next cycle all outputs at reset values and state ON. pu_req pulses in ON and pd_req pulses in OFF produce no transitions.
- Back-to-back: shutdown, wake, shutdown with T_RST=T_PWDN=T_RAIL=1 -> exact edge-by-edge output trace matching the timing rules, with no missed or extra pon_restart pulse.
